// File: rtl/reservation_station_pkg.sv
// Shared types, opcode enumeration and sizing for the ALU reservation station.
// Also holds the operand-capture helper used by both insert bypass and wakeup.
package reservation_station_pkg;

  localparam int DATA_W    = 32;
  localparam int ROB_POS_W = 5;
  localparam int OPENUM_W  = 6;
  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = $clog2(RS_SIZE);

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_POS_W-1:0] rob_pos_t;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP   = 6'd0,
    OPENUM_LUI   = 6'd1,
    OPENUM_AUIPC = 6'd2,
    OPENUM_JAL   = 6'd3,
    OPENUM_JALR  = 6'd4,
    OPENUM_BEQ   = 6'd5,
    OPENUM_BNE   = 6'd6,
    OPENUM_BLT   = 6'd7,
    OPENUM_BGE   = 6'd8,
    OPENUM_BLTU  = 6'd9,
    OPENUM_BGEU  = 6'd10,
    OPENUM_ADDI  = 6'd11,
    OPENUM_SLTI  = 6'd12,
    OPENUM_SLTIU = 6'd13,
    OPENUM_XORI  = 6'd14,
    OPENUM_ORI   = 6'd15,
    OPENUM_ANDI  = 6'd16,
    OPENUM_SLLI  = 6'd17,
    OPENUM_SRLI  = 6'd18,
    OPENUM_SRAI  = 6'd19,
    OPENUM_ADD   = 6'd20,
    OPENUM_SUB   = 6'd21,
    OPENUM_SLL   = 6'd22,
    OPENUM_SLT   = 6'd23,
    OPENUM_SLTU  = 6'd24,
    OPENUM_XOR   = 6'd25,
    OPENUM_SRL   = 6'd26,
    OPENUM_SRA   = 6'd27,
    OPENUM_OR    = 6'd28,
    OPENUM_AND   = 6'd29
  } openum_e;

  localparam rob_pos_t ZERO_ROB  = '0;
  localparam data_t    ZERO_WORD = '0;

  typedef struct packed {
    rob_pos_t tag;
    data_t    value;
  } operand_t;

  typedef struct packed {
    openum_e  op;
    operand_t src1;
    operand_t src2;
    data_t    imm;
    data_t    pc;
    rob_pos_t rob_tag;
  } rs_entry_t;

  // A pending operand grabs a matching CDB value; the ALU bus wins a tie.
  function automatic operand_t capture_operand(
    input operand_t cur,
    input rob_pos_t alu_tag,
    input data_t    alu_value,
    input rob_pos_t lsb_tag,
    input data_t    lsb_value
  );
    operand_t res;
    res = cur;
    if (cur.tag != ZERO_ROB) begin
      if (cur.tag == alu_tag) begin
        res.tag   = ZERO_ROB;
        res.value = alu_value;
      end else if (cur.tag == lsb_tag) begin
        res.tag   = ZERO_ROB;
        res.value = lsb_value;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_first_set.sv
// Lowest-index priority encoder: returns the index of the first set bit and
// whether any bit was set at all.
module rs_first_set
  import reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = RS_IDX_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued packets until both operands are
// resolved from the CDBs, then dispatches the lowest-index ready entry.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [ROB_POS_W-1:0] in_decode_rob_tag,
  input  logic [OPENUM_W-1:0]  in_decode_op,
  input  logic [DATA_W-1:0]    in_decode_value1,
  input  logic [ROB_POS_W-1:0] in_decode_tag1,
  input  logic [DATA_W-1:0]    in_decode_value2,
  input  logic [ROB_POS_W-1:0] in_decode_tag2,
  input  logic [DATA_W-1:0]    in_decode_imm,
  input  logic [DATA_W-1:0]    in_decode_pc,
  input  logic [ROB_POS_W-1:0] in_alu_cdb_rob_tag,
  input  logic [DATA_W-1:0]    in_alu_cdb_value,
  input  logic [ROB_POS_W-1:0] in_lsb_cdb_rob_tag,
  input  logic [DATA_W-1:0]    in_lsb_cdb_value,
  input  logic                 in_rob_rollback,
  output logic                 out_fetcher_full,
  output logic [OPENUM_W-1:0]  out_alu_op,
  output logic [DATA_W-1:0]    out_alu_value1,
  output logic [DATA_W-1:0]    out_alu_value2,
  output logic [DATA_W-1:0]    out_alu_imm,
  output logic [DATA_W-1:0]    out_alu_pc,
  output logic [ROB_POS_W-1:0] out_alu_rob_tag
);

  rs_entry_t           entries_q [RS_SIZE];
  rs_entry_t           entries_d [RS_SIZE];
  logic [RS_SIZE-1:0]  busy_q, busy_d;
  rs_entry_t           out_q, out_d;

  logic [RS_SIZE-1:0]  free_vec, ready_vec;
  logic [RS_IDX_W-1:0] free_idx, ready_idx;
  logic                free_found, ready_found;
  logic [RS_IDX_W:0]   busy_count;
  logic                insert_req;
  rs_entry_t           new_entry;

  assign free_vec   = ~busy_q;
  assign insert_req = (in_decode_rob_tag != ZERO_ROB);

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] &&
                     (entries_q[i].src1.tag == ZERO_ROB) &&
                     (entries_q[i].src2.tag == ZERO_ROB);
    end
  end

  rs_first_set #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
    .vec   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_first_set #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_sel (
    .vec   (ready_vec),
    .idx   (ready_idx),
    .found (ready_found)
  );

  // One spare slot is kept for the instruction already sitting in decode.
  always_comb begin
    busy_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_count = busy_count + (RS_IDX_W + 1)'(busy_q[i]);
    end
  end

  assign out_fetcher_full = (busy_count >= (RS_IDX_W + 1)'(RS_SIZE - 1));

  always_comb begin
    new_entry.op      = openum_e'(in_decode_op);
    new_entry.src1    = capture_operand(operand_t'{in_decode_tag1, in_decode_value1},
                                        in_alu_cdb_rob_tag, in_alu_cdb_value,
                                        in_lsb_cdb_rob_tag, in_lsb_cdb_value);
    new_entry.src2    = capture_operand(operand_t'{in_decode_tag2, in_decode_value2},
                                        in_alu_cdb_rob_tag, in_alu_cdb_value,
                                        in_lsb_cdb_rob_tag, in_lsb_cdb_value);
    new_entry.imm     = in_decode_imm;
    new_entry.pc      = in_decode_pc;
    new_entry.rob_tag = in_decode_rob_tag;
  end

  always_comb begin
    entries_d = entries_q;
    busy_d    = busy_q;
    out_d     = out_q;
    out_d.op  = OPENUM_NOP;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        entries_d[i].src1 = capture_operand(entries_q[i].src1,
                                            in_alu_cdb_rob_tag, in_alu_cdb_value,
                                            in_lsb_cdb_rob_tag, in_lsb_cdb_value);
        entries_d[i].src2 = capture_operand(entries_q[i].src2,
                                            in_alu_cdb_rob_tag, in_alu_cdb_value,
                                            in_lsb_cdb_rob_tag, in_lsb_cdb_value);
      end
    end

    if (ready_found) begin
      out_d             = entries_q[ready_idx];
      busy_d[ready_idx] = 1'b0;
    end

    // Insert only targets a slot free in registered state, never the one
    // being dispatched this cycle.
    if (insert_req && free_found) begin
      entries_d[free_idx] = new_entry;
      busy_d[free_idx]    = 1'b1;
    end

    if (in_rob_rollback) begin
      busy_d   = '0;
      out_d.op = OPENUM_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      out_q  <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      out_q  <= out_d;
    end
  end

  // Payload storage needs no reset: busy bits alone decide validity.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      entries_q <= entries_d;
    end
  end

  assign out_alu_op      = out_q.op;
  assign out_alu_value1  = out_q.src1.value;
  assign out_alu_value2  = out_q.src2.value;
  assign out_alu_imm     = out_q.imm;
  assign out_alu_pc      = out_q.pc;
  assign out_alu_rob_tag = out_q.rob_tag;

  // Decode must never issue into a full station, nor may both CDBs carry one tag.
  assert property (@(posedge clk) disable iff (rst)
    (rdy && insert_req && !in_rob_rollback) |-> free_found);

  assert property (@(posedge clk) disable iff (rst)
    (rdy && in_alu_cdb_rob_tag != ZERO_ROB) |-> (in_alu_cdb_rob_tag != in_lsb_cdb_rob_tag));

endmodule
